rr_onehot_arbiter: RTL and testbench

//   Round-robin arbiter sharing one resource among 8 requesters.

---
 rtl/rr_onehot_arbiter_if.sv | 12 +
 rtl/rr_onehot_arbiter.sv | 137 +++++++++++++
 tb/tb_rr_onehot_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between the eight requesters and the round-robin arbiter.
// The requester side is master; the arbiter is slave.
interface rr_onehot_arbiter_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  modport master (output req, input gnt, input gnt_idx, input gnt_valid, input preempt);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_valid, output preempt);
endinterface

// File: rtl/rr_onehot_arbiter.sv
// Eight-way round-robin arbiter with a registered one-hot grant and bounded tenure:
// an owner is rotated out after MAX_HOLD cycles whenever another requester is waiting.
module rr_onehot_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_onehot_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_t               state_r;
  logic [NUM_REQ-1:0]   gnt_r;
  logic [2:0]           idx_r;
  logic [2:0]           ptr_r;
  logic                 valid_r;
  logic                 preempt_r;
  logic [7:0]           hcnt_r;

  logic [NUM_REQ-1:0]   others_s;
  logic                 owner_req_s;
  logic [3:0]           idle_pick_s;
  logic [3:0]           next_pick_s;
  logic                 at_limit_s;

  // Returns {found, index} of the first set bit scanning start, start+1, ... modulo 8.
  function automatic logic [3:0] scan_f(input logic [NUM_REQ-1:0] vec, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = start + 3'(i);
      if (vec[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot_f(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

  // Candidate winners: from the pointer when idle, from owner+1 (owner excluded) otherwise.
  always_comb begin
    others_s    = bus.req & ~gnt_r;
    owner_req_s = bus.req[idx_r];
    idle_pick_s = scan_f(bus.req, ptr_r);
    next_pick_s = scan_f(others_s, idx_r + 3'd1);
    at_limit_s  = (hcnt_r >= MAX_HOLD_C);
  end

  // Arbitration state machine; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      gnt_r     <= 8'h00;
      idx_r     <= 3'd0;
      ptr_r     <= 3'd0;
      valid_r   <= 1'b0;
      preempt_r <= 1'b0;
      hcnt_r    <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          preempt_r <= 1'b0;
          if (idle_pick_s[3]) begin
            state_r <= GRANT;
            gnt_r   <= onehot_f(idle_pick_s[2:0]);
            idx_r   <= idle_pick_s[2:0];
            valid_r <= 1'b1;
            hcnt_r  <= 8'd1;
          end else begin
            state_r <= IDLE;
            gnt_r   <= 8'h00;
            idx_r   <= 3'd0;
            valid_r <= 1'b0;
            hcnt_r  <= 8'd0;
          end
        end
        GRANT: begin
          if (owner_req_s) begin
            if (!next_pick_s[3]) begin
              // Alone on the resource: tenure saturates so a late arrival rotates at once.
              preempt_r <= 1'b0;
              hcnt_r    <= at_limit_s ? MAX_HOLD_C : hcnt_r + 8'd1;
            end else if (!at_limit_s) begin
              preempt_r <= 1'b0;
              hcnt_r    <= hcnt_r + 8'd1;
            end else begin
              gnt_r     <= onehot_f(next_pick_s[2:0]);
              idx_r     <= next_pick_s[2:0];
              ptr_r     <= idx_r + 3'd1;
              hcnt_r    <= 8'd1;
              preempt_r <= 1'b1;
            end
          end else begin
            ptr_r     <= idx_r + 3'd1;
            preempt_r <= 1'b0;
            if (next_pick_s[3]) begin
              gnt_r   <= onehot_f(next_pick_s[2:0]);
              idx_r   <= next_pick_s[2:0];
              valid_r <= 1'b1;
              hcnt_r  <= 8'd1;
            end else begin
              state_r <= IDLE;
              gnt_r   <= 8'h00;
              idx_r   <= 3'd0;
              valid_r <= 1'b0;
              hcnt_r  <= 8'd0;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          gnt_r     <= 8'h00;
          idx_r     <= 3'd0;
          valid_r   <= 1'b0;
          preempt_r <= 1'b0;
          hcnt_r    <= 8'd0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_idx   = idx_r;
  assign bus.gnt_valid = valid_r;
  assign bus.preempt   = preempt_r;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed and randomized checks of rr_onehot_arbiter against an owner/pointer/tenure
// reference model built from the arbitration rules with plain integer arithmetic.
module tb_rr_onehot_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int BOUND    = 7 * MAX_HOLD + 1;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  rr_onehot_arbiter_if arb_if ();

  rr_onehot_arbiter #(.NUM_REQ(8), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (arb_if.slave)
  );

  // Reference model state: current owner (-1 when idle), next-scan pointer, tenure length.
  int m_owner;
  int m_ptr;
  int m_ten;
  int m_pre;
  int wait_cnt [8];
  int max_wait;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int first_from(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_gnt();
    return (m_owner < 0) ? 32'h0 : (32'h1 << m_owner);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_ten   = 0;
    m_pre   = 0;
    for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
  endtask

  task automatic model_step(input logic [7:0] r);
    logic [7:0] others;
    int         old;
    m_pre = 0;
    if (m_owner < 0) begin
      if (r != 8'h00) begin
        m_owner = first_from(r, m_ptr);
        m_ten   = 1;
      end
    end else if (r[m_owner]) begin
      others = r & ~(8'h01 << m_owner);
      if (others == 8'h00) begin
        m_ten = (m_ten + 1 > MAX_HOLD) ? MAX_HOLD : m_ten + 1;
      end else if (m_ten < MAX_HOLD) begin
        m_ten = m_ten + 1;
      end else begin
        old     = m_owner;
        m_ptr   = (old + 1) % 8;
        m_owner = first_from(others, old + 1);
        m_ten   = 1;
        m_pre   = 1;
      end
    end else begin
      old   = m_owner;
      m_ptr = (old + 1) % 8;
      if (r != 8'h00) begin
        m_owner = first_from(r, old + 1);
        m_ten   = 1;
      end else begin
        m_owner = -1;
        m_ten   = 0;
      end
    end
  endtask

  // One clock: drive req, let the edge happen, then compare on the falling edge.
  task automatic cycle(input logic [7:0] r);
    arb_if.req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    chk("gnt",       32'(arb_if.gnt),       exp_gnt());
    chk("gnt_idx",   32'(arb_if.gnt_idx),   (m_owner < 0) ? 32'h0 : 32'(m_owner));
    chk("gnt_valid", 32'(arb_if.gnt_valid), (m_owner < 0) ? 32'h0 : 32'h1);
    chk("preempt",   32'(arb_if.preempt),   32'(m_pre));
    for (int i = 0; i < 8; i++) begin
      if (r[i] && !arb_if.gnt[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    arb_if.req = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    chk("rst_gnt",     32'(arb_if.gnt),       32'h0);
    chk("rst_idx",     32'(arb_if.gnt_idx),   32'h0);
    chk("rst_valid",   32'(arb_if.gnt_valid), 32'h0);
    chk("rst_preempt", 32'(arb_if.preempt),   32'h0);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] rq;
    int         dens;
    n_tests    = 0;
    n_fail     = 0;
    max_wait   = 0;
    rst_n      = 1'b0;
    arb_if.req = 8'hFF;
    model_reset();
    @(negedge clk);

    // Reset with all requesting, then full round robin in MAX_HOLD slots.
    do_reset();
    for (int k = 0; k < 36; k++) begin
      cycle(8'hFF);
      chk("rr_gnt", 32'(arb_if.gnt), 32'h1 << ((k / MAX_HOLD) % 8));
      chk("rr_pre", 32'(arb_if.preempt), (k > 0 && k % MAX_HOLD == 0) ? 32'h1 : 32'h0);
    end

    // Single requester never preempted, then released to idle.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cycle(8'h20);
      chk("single_gnt", 32'(arb_if.gnt), 32'h20);
      chk("single_idx", 32'(arb_if.gnt_idx), 32'h5);
    end
    cycle(8'h00);
    chk("single_rel", 32'(arb_if.gnt), 32'h0);

    // Zero-bubble handoff from owner 3 to requester 6.
    do_reset();
    cycle(8'h08);
    cycle(8'h48);
    cycle(8'h40);
    chk("handoff_gnt", 32'(arb_if.gnt), 32'h40);
    chk("handoff_vld", 32'(arb_if.gnt_valid), 32'h1);

    // Wrap-around from owner 7, then skip of an idle line.
    do_reset();
    cycle(8'h80);
    cycle(8'h05);
    chk("wrap_gnt", 32'(arb_if.gnt), 32'h01);
    cycle(8'h04);
    chk("skip_gnt", 32'(arb_if.gnt), 32'h04);

    // Owner drops req on the edge its tenure would expire: plain release.
    do_reset();
    cycle(8'h02);
    cycle(8'h03);
    cycle(8'h03);
    cycle(8'h03);
    cycle(8'h01);
    chk("drop_at_limit_gnt", 32'(arb_if.gnt), 32'h01);
    chk("drop_at_limit_pre", 32'(arb_if.preempt), 32'h0);

    // Asynchronous reset between edges while a grant is held.
    do_reset();
    cycle(8'h10);
    cycle(8'h10);
    chk("async_pre_gnt", 32'(arb_if.gnt), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt",   32'(arb_if.gnt),       32'h0);
    chk("async_valid", 32'(arb_if.gnt_valid), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(8'h11);
    chk("async_after", 32'(arb_if.gnt), 32'h01);

    // Randomized traffic with sparse and dense phases.
    do_reset();
    rq = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      dens = ((n / 500) % 2 == 0) ? 30 : 6;
      for (int b = 0; b < 8; b++) begin
        if (rq[b]) begin
          if (b == m_owner) begin
            if ($urandom_range(0, 99) < 15) rq[b] = 1'b0;
          end else if ($urandom_range(0, 99) < 3) begin
            rq[b] = 1'b0;
          end
        end else if ($urandom_range(0, 99) < dens) begin
          rq[b] = 1'b1;
        end
      end
      cycle(rq);
    end
    chk("starvation_bound", (max_wait <= BOUND) ? 32'h1 : 32'h0, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
